// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the regfile write port, loads wait in a small FIFO,
// r15 writes are steered to the PC port, and decode reads with a write in flight are flagged.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [3:0]               alu_wa,
  input  logic [31:0]              alu_wd,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [3:0]               ld_wa,
  input  logic [31:0]              ld_wd,
  input  logic [3:0]               ra1,
  input  logic [3:0]               ra2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     we3,
  output logic [3:0]               wa3,
  output logic [31:0]              wd3,
  output logic                     pc_we,
  output logic [31:0]              pc_wd,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] QMAX = DEPTH[AW:0];

  logic [AW-1:0]    wptr, rptr;
  logic [3:0]       q_wa [DEPTH];
  logic [31:0]      q_wd [DEPTH];
  logic             push, pop, sel_vld;
  logic [3:0]       sel_wa;
  logic [31:0]      sel_wd;
  logic [DEPTH-1:0] live;
  logic             hit1, hit2;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign ld_ready = (q_count < QMAX);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (q_count != '0);

  always_comb begin
    sel_vld = alu_valid || pop;
    sel_wa  = alu_valid ? alu_wa : q_wa[rptr];
    sel_wd  = alu_valid ? alu_wd : q_wd[rptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      q_count <= '0;
      we3     <= 1'b0;
      wa3     <= '0;
      wd3     <= '0;
      pc_we   <= 1'b0;
      pc_wd   <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
      if (sel_vld && sel_wa != 4'd15) begin
        we3   <= 1'b1;
        wa3   <= sel_wa;
        wd3   <= sel_wd;
        pc_we <= 1'b0;
      end else if (sel_vld) begin
        we3   <= 1'b0;
        pc_we <= 1'b1;
        pc_wd <= sel_wd;
      end else begin
        we3   <= 1'b0;
        pc_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_wa[wptr] <= ld_wa;
      q_wd[wptr] <= ld_wd;
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    live = '0;
    hit1 = we3 && (wa3 == ra1);
    hit2 = we3 && (wa3 == ra2);
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = ((i - int'(rptr) + DEPTH) % DEPTH) < int'(q_count);
      if (live[i] && q_wa[i] == ra1) hit1 = 1'b1;
      if (live[i] && q_wa[i] == ra2) hit2 = 1'b1;
    end
  end

  assign hazard1 = (ra1 != 4'd15) && hit1;
  assign hazard2 = (ra2 != 4'd15) && hit2;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, each cycle compared
// against a queue-based reference of the writeback rules.
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk, rst_n;
  logic        alu_valid, ld_valid, ld_ready;
  logic [3:0]  alu_wa, ld_wa, ra1, ra2, wa3;
  logic [31:0] alu_wd, ld_wd, wd3, pc_wd;
  logic        hazard1, hazard2, we3, pc_we;
  logic [1:0]  q_count;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: pending loads in arrival order, plus the expected output stage.
  logic [35:0] mq[$];
  logic        m_we3, m_pcwe;
  logic [3:0]  m_wa3;
  logic [31:0] m_wd3, m_pcwd;
  bit          acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mhaz(input logic [3:0] ra);
    if (ra == 4'd15) return 1'b0;
    foreach (mq[i]) if (mq[i][35:32] == ra) return 1'b1;
    return m_we3 && (m_wa3 == ra);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we3 = 1'b0; m_pcwe = 1'b0; m_wa3 = '0; m_wd3 = '0; m_pcwd = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    int sz;
    bit selv;
    logic [35:0] sel;
    #1;
    sz = mq.size();
    chk("ld_ready", 32'(ld_ready), 32'(sz < DEPTH));
    chk("hazard1", 32'(hazard1), 32'(mhaz(ra1)));
    chk("hazard2", 32'(hazard2), 32'(mhaz(ra2)));
    acc  = ld_valid && (sz < DEPTH);
    selv = 1'b0;
    sel  = '0;
    if (alu_valid) begin
      selv = 1'b1;
      sel  = {alu_wa, alu_wd};
    end else if (sz > 0) begin
      selv = 1'b1;
      sel  = mq.pop_front();
    end
    if (acc) mq.push_back({ld_wa, ld_wd});
    if (!selv) begin
      m_we3 = 1'b0; m_pcwe = 1'b0;
    end else if (sel[35:32] == 4'd15) begin
      m_we3 = 1'b0; m_pcwe = 1'b1; m_pcwd = sel[31:0];
    end else begin
      m_we3 = 1'b1; m_pcwe = 1'b0; m_wa3 = sel[35:32]; m_wd3 = sel[31:0];
    end
    @(posedge clk);
    #1;
    chk("we3", 32'(we3), 32'(m_we3));
    chk("wa3", 32'(wa3), 32'(m_wa3));
    chk("wd3", wd3, m_wd3);
    chk("pc_we", 32'(pc_we), 32'(m_pcwe));
    chk("pc_wd", pc_wd, m_pcwd);
    chk("q_count", 32'(q_count), 32'(mq.size()));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; alu_valid = 0; alu_wa = 0; alu_wd = 0;
    ld_valid = 0; ld_wa = 0; ld_wd = 0; ra1 = 0; ra2 = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #12;
    chk("rst_we3", 32'(we3), 0);
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_wa3", 32'(wa3), 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_pc_wd", pc_wd, 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_hazard1", 32'(hazard1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ld_ready", 32'(ld_ready), 1);
    @(negedge clk);

    // ALU only: two back-to-back results
    alu_valid = 1; alu_wa = 4'd3; alu_wd = 32'h11;
    cycle();
    chk("alu_wa3_a", 32'(wa3), 3);
    chk("alu_wd3_a", wd3, 32'h11);
    alu_wa = 4'd4; alu_wd = 32'h22;
    cycle();
    chk("alu_wa3_b", 32'(wa3), 4);
    chk("alu_wd3_b", wd3, 32'h22);
    chk("alu_qcnt", 32'(q_count), 0);
    alu_valid = 0;
    cycle();

    // Contention: load parks behind a 3-cycle ALU burst
    ra1 = 4'd5;
    alu_valid = 1; alu_wa = 4'd7; alu_wd = 32'h70;
    ld_valid = 1; ld_wa = 4'd5; ld_wd = 32'hAA;
    cycle();
    ld_valid = 0;
    chk("cont_q1", 32'(q_count), 1);
    chk("cont_haz_q", 32'(hazard1), 1);
    cycle();
    cycle();
    chk("cont_q3", 32'(q_count), 1);
    alu_valid = 0;
    cycle();
    chk("cont_ld_wa3", 32'(wa3), 5);
    chk("cont_ld_wd3", wd3, 32'hAA);
    chk("cont_haz_out", 32'(hazard1), 1);
    cycle();
    chk("cont_haz_clr", 32'(hazard1), 0);

    // Full: DEPTH loads fill the queue while the ALU owns the port
    alu_valid = 1; alu_wa = 4'd9; alu_wd = 32'h99;
    ld_valid = 1; ld_wa = 4'd1; ld_wd = 32'h1001;
    cycle();
    ld_wa = 4'd2; ld_wd = 32'h1002;
    cycle();
    ld_wa = 4'd3; ld_wd = 32'h1003;
    chk("full_ready", 32'(ld_ready), 0);
    chk("full_cnt", 32'(q_count), 2);
    cycle();
    chk("full_hold", 32'(q_count), 2);
    alu_valid = 0;
    cycle();
    chk("full_out1", 32'(wa3), 1);
    chk("full_no_acc", 32'(acc), 0);
    cycle();
    chk("full_out2", 32'(wa3), 2);
    chk("full_acc3", 32'(acc), 1);
    ld_valid = 0;
    cycle();
    chk("full_out3", 32'(wa3), 3);

    // r15 goes to the PC port only
    ra1 = 4'd15;
    alu_valid = 1; alu_wa = 4'd15; alu_wd = 32'h100;
    cycle();
    alu_valid = 0;
    chk("r15_pc_we", 32'(pc_we), 1);
    chk("r15_pc_wd", pc_wd, 32'h100);
    chk("r15_we3", 32'(we3), 0);
    chk("r15_haz", 32'(hazard1), 0);
    cycle();

    // Random traffic: ALU bursts interleaved with held-until-accepted loads
    for (int n = 0; n < 1200; n++) begin
      alu_valid = ($urandom_range(0, 9) < 5);
      alu_wa = 4'($urandom_range(0, 15)); alu_wd = $urandom;
      ra1 = 4'($urandom_range(0, 15)); ra2 = 4'($urandom_range(0, 15));
      if (!ld_valid || acc) begin
        ld_valid = ($urandom_range(0, 2) != 0);
        ld_wa = 4'($urandom_range(0, 15)); ld_wd = $urandom;
      end
      cycle();
    end

    // Reset mid-flight: two queued loads plus a pending write are dropped
    alu_valid = 1; alu_wa = 4'd6; alu_wd = 32'h66;
    ld_valid = 0;
    while (mq.size() > 0) begin alu_valid = 0; cycle(); end
    alu_valid = 1; ld_valid = 1; ld_wa = 4'd8; ld_wd = 32'h88;
    cycle();
    ld_wa = 4'd10; ld_wd = 32'hA0;
    cycle();
    ld_valid = 0;
    chk("mid_q2", 32'(q_count), 2);
    chk("mid_we3", 32'(we3), 1);
    alu_valid = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_we3", 32'(we3), 0);
    chk("mid_rst_q", 32'(q_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ra1 = 4'd8; ra2 = 4'd10;
    for (int n = 0; n < 4; n++) cycle();
    chk("post_rst_ready", 32'(ld_ready), 1);

    for (int n = 0; n < 300; n++) begin
      alu_valid = ($urandom_range(0, 9) < 3);
      alu_wa = 4'($urandom_range(0, 15)); alu_wd = $urandom;
      ra1 = 4'($urandom_range(0, 15)); ra2 = 4'($urandom_range(0, 15));
      if (!ld_valid || acc) begin
        ld_valid = ($urandom_range(0, 1) != 0);
        ld_wa = 4'($urandom_range(0, 15)); ld_wd = $urandom;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter feeding the single write port (we3/wa3/wd3) of the register file. It merges the one-per-cycle ALU result stream with load results from the memory unit, buffering loads in a small queue when the ALU owns the port. It diverts writes addressed to r15 onto a separate PC write port, because the register file holds only r0–r14. It also flags decode-stage read addresses that have a write still in flight.

## Interface
Parameters:
- DEPTH, 2, load queue depth in entries; power of two, ≥2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result present this cycle; always accepted, no backpressure.
- alu_wa  input  4  ALU destination register.
- alu_wd  input  32  ALU result.
- ld_valid  input  1  load result offered.
- ld_ready  output  1  queue can accept a load this cycle.
- ld_wa  input  4  load destination register.
- ld_wd  input  32  load data.
- ra1, ra2  input  4  decode-stage read addresses (same as regfile ra1/ra2).
- hazard1, hazard2  output  1  pending write to ra1 / ra2 not yet visible in regfile.
- we3  output  1  regfile write enable.
- wa3  output  4  regfile write address, never 15 while we3=1.
- wd3  output  32  regfile write data.
- pc_we  output  1  write to r15 (branch-by-writeback).
- pc_wd  output  32  new PC value.
- q_count  output  clog2(DEPTH)+1  loads currently queued.

## Operation
- Load queue: circular FIFO of DEPTH entries {wa, wd}, read/write pointers plus count.
- Push when ld_valid && ld_ready; ld_ready = (q_count < DEPTH), from registered count only. A pop in the same cycle does not raise ld_ready that cycle.
- Selection each cycle:
  - alu_valid=1 → ALU result selected. Queue holds.
  - otherwise q_count>0 → queue head selected and popped.
  - otherwise nothing selected.
- Push and pop in the same cycle: count unchanged, both pointers advance. A load pushed at cycle N cannot be popped before N+1.
- Output stage register, loaded every cycle from the selection:
  - selected wa≠15 → we3=1, wa3=wa, wd3=wd, pc_we=0.
  - selected wa=15 → pc_we=1, pc_wd=wd, we3=0. wa3/wd3 hold their previous values.
  - nothing selected → we3=0, pc_we=0. Data outputs hold.
- Ordering: ALU results leave in arrival order, and loads leave in arrival order. There is no ordering between an ALU result and a load. Decode uses hazard flags to avoid WAW/RAW across the two streams.
- Hazards:
  - hazard1 = (ra1≠15) && (any valid queue entry has wa==ra1 || (we3 && wa3==ra1)).
  - hazard2 is the same for ra2.
  - Both are combinational from registered state.
  - ra=15 never flags, because the regfile supplies PC+8 for r15.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, rst_n=0) clears:
  - we3=0, pc_we=0, wa3=0, wd3=0, pc_wd=0.
  - q_count=0, pointers=0.
  - ld_ready=1 once rst_n is high, hazard1/hazard2=0.
- Reset mid-operation: queued loads and the pending output are discarded, with no write issued.
- ALU latency: alu_valid at edge N → we3/pc_we high during cycle N+1. The regfile commits at edge N+2.
- Load latency, uncontended: pushed at edge N → selected in cycle N+1 → we3 during N+2.
- Each ALU-busy cycle delays queued loads by one cycle each. Continuous alu_valid starves the queue; this is legal, and upstream guarantees gaps.
- Full: q_count=DEPTH → ld_ready=0. ld_valid is ignored (upstream holds the load) until the cycle after a pop.

## Test plan
- ALU only:
  - Stimulus: alu_valid pulses wa=3,wd=0x11 then wa=4,wd=0x22 on consecutive edges.
  - Required: we3=1 for two cycles starting N+1 with (3,0x11),(4,0x22); q_count stays 0.
- Contention:
  - Stimulus: ld (wa=5,0xAA) pushed with alu_valid held 3 cycles.
  - Required: q_count=1 for 3 cycles; load written only after the ALU stream ends; hazard1=1 while ra1=5 and the entry is queued or at output, then 0.
- Full/backpressure:
  - Stimulus: DEPTH=2, alu_valid continuous, ld_valid continuous with wa=1,2,3.
  - Required: ld_ready=0 after two pushes; third load not accepted; after alu_valid drops, loads issue 1,2 then 3 is accepted.
- r15 divert:
  - Stimulus: alu wa=15, wd=0x100.
  - Required: pc_we=1, pc_wd=0x100, we3=0 next cycle; hazard1=0 with ra1=15.
- Pointer wrap:
  - Stimulus: 7 loads through a DEPTH=2 queue, interleaved with ALU bursts.
  - Required: writes emerge in load order with correct data; count never exceeds 2.
- Reset mid-flight:
  - Stimulus: 2 queued loads plus a pending we3, then rst_n low for 1 cycle.
  - Required: we3=0, q_count=0, ld_ready=1 after release; no queued write ever appears.
